led_pwm: RTL and testbench
==========================

# led_pwm

Three-channel 8-bit PWM controller for the board RGB LED. It is a far-bus peripheral behind the bridge and takes over from the plain three-bit pin register. The CPU writes per-channel duty values. The block runs a free-running prescaled 8-bit phase counter, compares it against each duty, and holds every duty change until the next PWM period boundary so the LED never glitches. Its register interface matches the other far peripherals (UART, timer, PLIC): request/ready handshake, word-addressed registers.

## Interface
Parameters:
- PRESCALE, 390, clock cycles per phase tick; PWM period = 256 × PRESCALE cycles (≈1 kHz at 100 MHz); legal range ≥ 1.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset: synchronous, active-high, single clock domain.
- i_request  in  1  bus request; held high by the bridge until o_ready.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  3  word index, byte address bits [4:2].
- i_wdata  in  32  write data.
- o_rdata  out  32  read data; valid while o_ready = 1.
- o_ready  out  1  one-cycle completion pulse.
- o_led  out  3  PWM outputs; bit 0 = R, bit 1 = G, bit 2 = B.

## Operation
Register map (unmapped indices 6–7 read 0; writes to them are ignored):
- 0 CONTROL (rw):
  - bit0 ENABLE.
  - bit1 INVERT (active-low LEDs).
  - Other bits read 0.
- 1/2/3 DUTY_R/G/B (rw, bits[7:0]):
  - A write stores to the channel's pending register and sets that channel's pending flag.
  - A read returns the pending value.
- 4 STATUS (ro):
  - bits[2:0] pending flags.
  - bits[15:8] current phase.
- 5 ACTIVE (ro): bits[7:0] active R, bits[15:8] active G, bits[23:16] active B.

Prescaler and phase:
- The prescaler counts 0..PRESCALE-1. It emits a tick on the cycle the count equals PRESCALE-1, then wraps to 0.
- Phase (8 bits) increments on each tick, wrapping 255 → 0.
- The wrap event is tick && phase == 255.

Output generation:
- o_led[n] = ENABLE ? ((phase < active[n]) ^ INVERT) : INVERT.
- duty 0: output always off. duty 255: on for 255 of 256 phases. There is no 100% mode.

Duty update rules:
- On the wrap event, every channel with its pending flag set copies pending → active and clears the flag.
- A DUTY write in the same cycle as the wrap event goes straight to active, and the flag stays clear.
- While ENABLE = 0:
  - prescaler and phase are held at 0;
  - DUTY writes go straight to active;
  - no flags are set.
- Writing CONTROL with ENABLE 1 → 0 copies all pending values to active and clears all flags.
- Writing ENABLE 0 → 1 starts counting from phase 0 / prescaler 0.

Handshake:
- A transaction is accepted on any cycle with i_request = 1 and o_ready = 0.
- The register write or read capture happens exactly once per accepted transaction.
- Writes update registers only; o_rdata is 0 on writes.

## Timing
- Reset values:
  - o_ready = 0, o_rdata = 0, o_led = 3'b000.
  - CONTROL, pending, active, flags, prescaler and phase all 0.
- Reset mid-transaction: o_ready drops the next cycle and no write lands after reset is sampled.
- Ready behaviour:
  - o_ready rises the cycle after acceptance and stays high for exactly one cycle.
  - With i_request held high, o_ready toggles 1,0,1,0. Each 1 completes one transaction.
- Register outputs:
  - o_rdata is registered and changes only with o_ready.
  - Output latency for a register write is 1 cycle, since registers update in the acceptance cycle.
- o_led timing:
  - o_led is registered: it reflects phase/active/CONTROL one cycle after they change.
  - A CONTROL write therefore affects o_led 2 cycles after acceptance.
- PRESCALE = 1 gives a tick every cycle and a 256-cycle period.

## Test plan
- Reset and defaults: reset with no bus activity, PRESCALE = 1 → o_led = 000 throughout; reads of indices 0–5 all return 0, each completing with a single o_ready pulse.
- Basic duty: with ENABLE = 0 write DUTY_R = 64, DUTY_G = 128, DUTY_B = 255, then CONTROL = 1 → over 256 cycles the high counts are R = 64, G = 128, B = 255; the period repeats exactly.
- Glitch-free update: while enabled at phase 10, write DUTY_R = 200 → ACTIVE[7:0] stays at its old value and STATUS bit0 = 1 until the wrap; phase-0 output then uses 200 and the flag clears.
- Write coincident with the wrap: time a DUTY_G write into the wrap cycle → active G updates immediately and STATUS bit1 stays 0.
- Invert and disable: CONTROL = 3 with duty 0 → o_led = 111; CONTROL = 2 → o_led = 111 and the phase reads 0 frozen; pending values appear in ACTIVE.
- Handshake and unmapped access: hold i_request high for 6 cycles writing index 7 → 3 o_ready pulses, no register changes, rdata = 0; reset asserted mid-transaction → o_ready = 0 the next cycle.

Source files
------------

// File: rtl/led_pwm.sv
// led_pwm: three-channel 8-bit PWM for the board RGB LED, far-bus slave.
// Ports: i_clock, i_reset (sync, active-high); request/ready bus with
//   i_rw, i_address[2:0] (word index), i_wdata, o_rdata, o_ready;
//   o_led[2:0] = {B, G, R} PWM outputs.
module led_pwm #(
    parameter int PRESCALE = 390
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [2:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic [2:0]  o_led
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [2:0] REG_CONTROL = 3'd0;
    localparam logic [2:0] REG_DUTY_R  = 3'd1;
    localparam logic [2:0] REG_DUTY_G  = 3'd2;
    localparam logic [2:0] REG_DUTY_B  = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_ACTIVE  = 3'd5;

    logic            enable;
    logic            invert;
    logic [PW-1:0]   pre;
    logic [7:0]      phase;
    logic [2:0][7:0] pending;
    logic [2:0][7:0] active;
    logic [2:0]      flags;

    logic        accept;
    logic        wr;
    logic        ctrl_wr;
    logic        stop;
    logic        halt;
    logic        tick;
    logic        wrap;
    logic [2:0]  duty_sel;
    logic [2:0]  cmp;
    logic [31:0] rd_val;
    logic        unused;

    assign accept  = i_request && !o_ready;
    assign wr      = accept && i_rw;
    assign ctrl_wr = wr && (i_address == REG_CONTROL);

    assign duty_sel[0] = wr && (i_address == REG_DUTY_R);
    assign duty_sel[1] = wr && (i_address == REG_DUTY_G);
    assign duty_sel[2] = wr && (i_address == REG_DUTY_B);

    // ENABLE 1 -> 0: flush every pending value to active.
    assign stop = ctrl_wr && enable && !i_wdata[0];
    // Counters sit at zero while disabled, including the disabling cycle.
    assign halt = !enable || (ctrl_wr && !i_wdata[0]);

    assign tick = enable && (pre == PRE_MAX);
    assign wrap = tick && (phase == 8'hFF);

    assign unused = ^i_wdata[31:8];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            enable <= 1'b0;
            invert <= 1'b0;
        end else if (ctrl_wr) begin
            enable <= i_wdata[0];
            invert <= i_wdata[1];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || halt) begin
            pre   <= '0;
            phase <= '0;
        end else if (tick) begin
            pre   <= '0;
            phase <= phase + 8'd1;
        end else begin
            pre   <= pre + PW'(1);
        end
    end

    // Later assignments override earlier ones: a write in the wrap
    // cycle lands directly in active and leaves its flag clear.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pending <= '0;
            active  <= '0;
            flags   <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (wrap && flags[n]) begin
                    active[n] <= pending[n];
                    flags[n]  <= 1'b0;
                end
                if (duty_sel[n]) begin
                    pending[n] <= i_wdata[7:0];
                    if (!enable || wrap) begin
                        active[n] <= i_wdata[7:0];
                        flags[n]  <= 1'b0;
                    end else begin
                        flags[n]  <= 1'b1;
                    end
                end
            end
            if (stop) begin
                active <= pending;
                flags  <= '0;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (i_address)
            REG_CONTROL: rd_val = {30'd0, invert, enable};
            REG_DUTY_R:  rd_val = {24'd0, pending[0]};
            REG_DUTY_G:  rd_val = {24'd0, pending[1]};
            REG_DUTY_B:  rd_val = {24'd0, pending[2]};
            REG_STATUS:  rd_val = {16'd0, phase, 5'd0, flags};
            REG_ACTIVE:  rd_val = {8'd0, active[2], active[1], active[0]};
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_ready <= 1'b0;
            o_rdata <= '0;
        end else begin
            o_ready <= accept;
            if (accept) begin
                o_rdata <= i_rw ? 32'd0 : rd_val;
            end
        end
    end

    always_comb begin
        cmp = '0;
        for (int n = 0; n < 3; n++) begin
            cmp[n] = phase < active[n];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_led <= 3'b000;
        end else if (enable) begin
            o_led <= cmp ^ {3{invert}};
        end else begin
            o_led <= {3{invert}};
        end
    end

endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm: self-checking bench for led_pwm with PRESCALE = 1.
// Bus reads/writes push expected rdata to a scoreboard popped on o_ready.
module tb_led_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [2:0]  led;

    led_pwm #(.PRESCALE(1)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_request (req),
        .i_rw      (rw),
        .i_address (addr),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .o_ready   (ready),
        .o_led     (led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } sb_t;

    sb_t sbq[$];

    typedef struct {
        logic        rw;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk(e.name, rdata & e.mask, e.exp);
            end
        end
    end

    task automatic bus(input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m, input string name);
        int n;
        sb_t s;
        req   = 1'b1;
        rw    = w;
        addr  = a;
        wdata = d;
        s.exp  = e;
        s.mask = m;
        s.name = name;
        sbq.push_back(s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 8);
        if (ready !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e,
                      input string name);
        bus(1'b0, a, 32'd0, e, 32'hFFFF_FFFF, name);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      input string name);
        bus(1'b1, a, d, 32'd0, 32'hFFFF_FFFF, name);
    endtask

    task automatic led_hold(input int cycles, input logic [2:0] e,
                            input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            if (led !== e) bad++;
            @(negedge clk);
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int duty[3];
        int pulses;

        tbl.push_back('{1'b0, 3'd0, 32'd0, 32'd0, "rd_ctrl_rst"});
        tbl.push_back('{1'b0, 3'd1, 32'd0, 32'd0, "rd_r_rst"});
        tbl.push_back('{1'b0, 3'd2, 32'd0, 32'd0, "rd_g_rst"});
        tbl.push_back('{1'b0, 3'd3, 32'd0, 32'd0, "rd_b_rst"});
        tbl.push_back('{1'b0, 3'd4, 32'd0, 32'd0, "rd_stat_rst"});
        tbl.push_back('{1'b0, 3'd5, 32'd0, 32'd0, "rd_act_rst"});
        tbl.push_back('{1'b1, 3'd1, 32'd64, 32'd0, "wr_r"});
        tbl.push_back('{1'b1, 3'd2, 32'd128, 32'd0, "wr_g"});
        tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0, "wr_b"});
        tbl.push_back('{1'b0, 3'd1, 32'd0, 32'd64, "rd_r"});
        tbl.push_back('{1'b0, 3'd2, 32'd0, 32'd128, "rd_g"});
        tbl.push_back('{1'b0, 3'd3, 32'd0, 32'd255, "rd_b"});
        tbl.push_back('{1'b0, 3'd5, 32'd0, 32'h00FF_8040, "rd_act_dis"});
        tbl.push_back('{1'b0, 3'd4, 32'd0, 32'd0, "rd_stat_dis"});
        tbl.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0, "wr_6"});
        tbl.push_back('{1'b0, 3'd6, 32'd0, 32'd0, "rd_6"});
        tbl.push_back('{1'b1, 3'd0, 32'hFFFF_FFFE, 32'd0, "wr_ctrl_inv"});
        tbl.push_back('{1'b0, 3'd0, 32'd0, 32'd2, "rd_ctrl_inv"});
        tbl.push_back('{1'b1, 3'd0, 32'd0, 32'd0, "wr_ctrl_0"});
        tbl.push_back('{1'b0, 3'd0, 32'd0, 32'd0, "rd_ctrl_0"});

        duty = '{64, 128, 255};

        rst   = 1'b1;
        req   = 1'b0;
        rw    = 1'b0;
        addr  = 3'd0;
        wdata = 32'd0;
        repeat (4) @(negedge clk);
        chk("led_in_rst", {29'd0, led}, 32'd0);
        chk("ready_in_rst", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        led_hold(20, 3'b000, "led_after_rst");

        foreach (tbl[i]) begin
            bus(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp,
                32'hFFFF_FFFF, tbl[i].name);
        end

        // Enable: first sample shows phase 0.
        wr(3'd0, 32'd1, "wr_ctrl_en");
        for (int p = 0; p < 2; p++) begin
            int hi[3];
            int bad;
            logic [2:0] e;
            hi = '{0, 0, 0};
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                for (int c = 0; c < 3; c++) begin
                    e[c] = (k < duty[c]);
                    hi[c] += int'(led[c]);
                end
                if (led !== e) bad++;
                @(negedge clk);
            end
            chk("r_high", 32'(hi[0]), 32'd64);
            chk("g_high", 32'(hi[1]), 32'd128);
            chk("b_high", 32'(hi[2]), 32'd255);
            chk("pattern", 32'(bad), 32'd0);
        end

        // Phase is 1 here; land the write at phase 10.
        repeat (9) @(negedge clk);
        wr(3'd1, 32'd200, "wr_r_200");
        rd(3'd4, 32'h0000_0C01, "stat_pend");
        rd(3'd5, 32'h00FF_8040, "act_old");
        rd(3'd1, 32'd200, "rd_r_pend");
        repeat (236) @(negedge clk);
        rd(3'd4, 32'h0000_FE01, "stat_prewrap");
        rd(3'd4, 32'h0000_0000, "stat_postwrap");
        rd(3'd5, 32'h00FF_80C8, "act_new");
        begin
            int hr;
            hr = 0;
            for (int k = 0; k < 256; k++) begin
                hr += int'(led[0]);
                @(negedge clk);
            end
            chk("r_high_200", 32'(hr), 32'd200);
        end

        // Phase is 4 here; land the G write on the wrap cycle.
        repeat (251) @(negedge clk);
        wr(3'd2, 32'h30, "wr_g_wrap");
        rd(3'd4, 32'h0000_0100, "stat_wrapwr");
        rd(3'd5, 32'h00FF_30C8, "act_wrapwr");

        wr(3'd3, 32'h55, "wr_b_pend");
        bus(1'b0, 3'd4, 32'd0, 32'd4, 32'h0000_0007, "stat_b_flag");
        rd(3'd5, 32'h00FF_30C8, "act_b_old");
        wr(3'd0, 32'd2, "wr_ctrl_dis_inv");
        rd(3'd5, 32'h0055_30C8, "act_flushed");
        rd(3'd4, 32'd0, "stat_dis");
        led_hold(20, 3'b111, "led_dis_inv");
        rd(3'd4, 32'd0, "stat_frozen");

        wr(3'd1, 32'd0, "wr_r0");
        wr(3'd2, 32'd0, "wr_g0");
        wr(3'd3, 32'd0, "wr_b0");
        rd(3'd5, 32'd0, "act_direct");
        rd(3'd4, 32'd0, "stat_direct");
        wr(3'd0, 32'd3, "wr_ctrl_3");
        led_hold(300, 3'b111, "led_inv_duty0");
        rd(3'd0, 32'd3, "rd_ctrl_3");
        wr(3'd0, 32'd0, "wr_ctrl_off");
        led_hold(10, 3'b000, "led_off");

        // Request held 6 cycles on unmapped index 7.
        req   = 1'b1;
        rw    = 1'b1;
        addr  = 3'd7;
        wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            sb_t s;
            s.exp  = 32'd0;
            s.mask = 32'hFFFF_FFFF;
            s.name = "held_wr7";
            sbq.push_back(s);
        end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        req = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd3);
        @(negedge clk);
        rd(3'd0, 32'd0, "ctrl_after7");
        rd(3'd1, 32'd0, "r_after7");
        rd(3'd3, 32'd0, "b_after7");
        rd(3'd5, 32'd0, "act_after7");
        rd(3'd7, 32'd0, "rd_7");

        // Reset while the request is still held high.
        wr(3'd1, 32'h77, "wr_r77");
        begin
            sb_t s;
            s.exp  = 32'd0;
            s.mask = 32'hFFFF_FFFF;
            s.name = "rst_mid_wr";
            sbq.push_back(s);
        end
        req   = 1'b1;
        rw    = 1'b1;
        addr  = 3'd2;
        wdata = 32'h99;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(3'd1, 32'd0, "r_after_rst");
        rd(3'd2, 32'd0, "g_after_rst");
        rd(3'd5, 32'd0, "act_after_rst");
        chk("led_after_mid_rst", {29'd0, led}, 32'd0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
